// File: rtl/sampler_dma_pkg.sv
// Shared types and constants for the sampler DMA voice arbitration logic.
package sampler_dma_pkg;

    localparam int SAMPLER_NUM_VOICES = 4;
    localparam int SAMPLER_DMA_ADDR_W = 32;
    localparam int SAMPLER_DMA_LEN_W  = 8;

    // Arbiter FSM: idle/arbitrating, AR issued and waiting, R beats in flight.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } dma_arb_state_t;

    // Next index in a ring of n entries, wrapping from n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sampler_dma_voice_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after ptr wins,
// so the previous winner is always considered last.
module rr_arbiter
    import sampler_dma_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the ring once starting after ptr and latch the first active request.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'(rr_next(int'(cand), N));
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
        any = found;
    end

endmodule

// File: rtl/sampler_dma_voice_arbiter.sv
// Shares one AXI4 read master among the per-voice DMA FSMs. One burst is in flight
// at a time; the winning voice keeps its grant from AR issue until its RLAST beat.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ARB_IDLE | no burst owned; arbitrate among voice_req every cycle
//  ARB_ADDR | AR presented for the granted voice, waiting for arready
//  ARB_DATA | AR accepted, counting R beats until RLAST
module sampler_dma_voice_arbiter
    import sampler_dma_pkg::*;
#(
    parameter int NUM_VOICES  = SAMPLER_NUM_VOICES,
    parameter int ADDR_WIDTH  = SAMPLER_DMA_ADDR_W,
    parameter int LEN_WIDTH   = SAMPLER_DMA_LEN_W,
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                             axi_dma_master_aclk,
    input  logic                             axi_dma_master_aresetn,
    input  logic [NUM_VOICES-1:0]            voice_req,
    input  logic [NUM_VOICES*ADDR_WIDTH-1:0] voice_addr,
    input  logic [NUM_VOICES*LEN_WIDTH-1:0]  voice_len,
    output logic [NUM_VOICES-1:0]            voice_gnt,
    output logic [NUM_VOICES-1:0]            voice_done,
    output logic [IDX_W-1:0]                 rd_voice_idx,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic [LEN_WIDTH-1:0]             m_arlen,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    input  logic                             m_rvalid,
    input  logic                             m_rready,
    input  logic                             m_rlast,
    output logic                             busy,
    output logic                             proto_err
);

    dma_arb_state_t         state;
    logic [NUM_VOICES-1:0]  gnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [ADDR_WIDTH-1:0]  araddr_r;
    logic [LEN_WIDTH-1:0]   arlen_r;
    logic                   arvalid_r;
    logic [IDX_W-1:0]       rr_ptr;
    logic [LEN_WIDTH:0]     beat_cnt;
    logic                   err_r;

    logic [NUM_VOICES-1:0]  arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic                   beat;
    logic [LEN_WIDTH:0]     arlen_ext;

    rr_arbiter #(
        .N     (NUM_VOICES),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (voice_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Pick the winning voice's address and length from the flat request buses.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = voice_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = voice_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign beat      = m_rvalid & m_rready;
    assign arlen_ext = {1'b0, arlen_r};

    // Arbitration, AR channel, beat counting and protocol error tracking.
    always_ff @(posedge axi_dma_master_aclk or negedge axi_dma_master_aresetn) begin
        if (!axi_dma_master_aresetn) begin
            state     <= ARB_IDLE;
            gnt_r     <= '0;
            idx_r     <= '0;
            araddr_r  <= '0;
            arlen_r   <= '0;
            arvalid_r <= 1'b0;
            rr_ptr    <= IDX_W'(NUM_VOICES - 1);
            beat_cnt  <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // R data with no burst outstanding is an interconnect fault.
                    if (m_rvalid) begin
                        err_r <= 1'b1;
                    end
                    if (arb_any) begin
                        gnt_r     <= arb_gnt;
                        idx_r     <= arb_idx;
                        araddr_r  <= sel_addr;
                        arlen_r   <= sel_len;
                        rr_ptr    <= arb_idx;
                        arvalid_r <= 1'b1;
                        state     <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (m_rvalid) begin
                        err_r <= 1'b1;
                    end
                    if (m_arready) begin
                        arvalid_r <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (beat) begin
                        // Saturate so a runaway burst cannot wrap back into a "valid" count.
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (m_rlast) begin
                            // beat_cnt holds the beats before this one; a correct burst has arlen of them.
                            if (beat_cnt != arlen_ext) begin
                                err_r <= 1'b1;
                            end
                            gnt_r <= '0;
                            state <= ARB_IDLE;
                        end else if (beat_cnt > arlen_ext) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // The done pulse must coincide with the RLAST handshake, so it is not registered.
    always_comb begin
        voice_done = '0;
        if (state == ARB_DATA && beat && m_rlast) begin
            voice_done = gnt_r;
        end
    end

    assign voice_gnt    = gnt_r;
    assign rd_voice_idx = idx_r;
    assign m_araddr     = araddr_r;
    assign m_arlen      = arlen_r;
    assign m_arvalid    = arvalid_r;
    assign busy         = (state != ARB_IDLE);
    assign proto_err    = err_r;

endmodule

// File: tb/tb_sampler_dma_voice_arbiter.sv
// Directed bench for sampler_dma_voice_arbiter. Inputs change and outputs are
// checked 1 time unit after the falling clock edge; the DUT samples on the rising edge.
module tb_sampler_dma_voice_arbiter;

    localparam int NV = 4;
    localparam int AW = 32;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NV-1:0]     voice_req;
    logic [NV*AW-1:0]  voice_addr;
    logic [NV*LW-1:0]  voice_len;
    logic [NV-1:0]     voice_gnt;
    logic [NV-1:0]     voice_done;
    logic [1:0]        rd_voice_idx;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic              m_arvalid;
    logic              m_arready;
    logic              m_rvalid;
    logic              m_rready;
    logic              m_rlast;
    logic              busy;
    logic              proto_err;

    logic [AW-1:0]     addr_tab [NV];
    logic [LW-1:0]     len_tab  [NV];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        voice_addr = '0;
        voice_len  = '0;
        for (int i = 0; i < NV; i++) begin
            voice_addr[i*AW +: AW] = addr_tab[i];
            voice_len[i*LW +: LW]  = len_tab[i];
        end
    end

    sampler_dma_voice_arbiter #(
        .NUM_VOICES (NV),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .axi_dma_master_aclk    (clk),
        .axi_dma_master_aresetn (rst_n),
        .voice_req              (voice_req),
        .voice_addr             (voice_addr),
        .voice_len              (voice_len),
        .voice_gnt              (voice_gnt),
        .voice_done             (voice_done),
        .rd_voice_idx           (rd_voice_idx),
        .m_araddr               (m_araddr),
        .m_arlen                (m_arlen),
        .m_arvalid              (m_arvalid),
        .m_arready              (m_arready),
        .m_rvalid               (m_rvalid),
        .m_rready               (m_rready),
        .m_rlast                (m_rlast),
        .busy                   (busy),
        .proto_err              (proto_err)
    );

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Wait for AR, check it is held steady for ar_wait extra cycles, then accept it.
    // Optionally pulses rvalid while AR is pending and tracks the resulting error flag.
    task automatic addr_phase(input int v, input int ar_wait, input int rv_pulse_at,
                              input int exp_wait, input string tag);
        int w;
        logic [NV-1:0] exp_g;
        logic exp_e;
        exp_g = NV'(1) << v;
        w = 0;
        while (!m_arvalid && w < 20) begin
            cyc();
            w++;
        end
        n_cmp++;
        if (m_arvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s arvalid_timeout: got %b want 1 within 20 cycles", tag, m_arvalid);
            return;
        end
        if (exp_wait >= 0) begin
            n_cmp++;
            if (w != exp_wait) begin
                n_bad++;
                $display("FAIL %s ar_latency: got %0d want %0d", tag, w, exp_wait);
            end
        end
        for (int c = 0; c <= ar_wait; c++) begin
            m_rvalid = (c == rv_pulse_at);
            #1;
            n_cmp++;
            if (voice_gnt !== exp_g || rd_voice_idx !== 2'(v) || busy !== 1'b1 || m_arvalid !== 1'b1) begin
                n_bad++;
                $display("FAIL %s ar_ctrl c=%0d: got gnt=%b idx=%0d busy=%b arvalid=%b want gnt=%b idx=%0d busy=1 arvalid=1",
                         tag, c, voice_gnt, rd_voice_idx, busy, m_arvalid, exp_g, v);
            end
            n_cmp++;
            if (m_araddr !== addr_tab[v] || m_arlen !== len_tab[v]) begin
                n_bad++;
                $display("FAIL %s ar_payload c=%0d: got addr=%h len=%0d want addr=%h len=%0d",
                         tag, c, m_araddr, m_arlen, addr_tab[v], len_tab[v]);
            end
            if (rv_pulse_at >= 0) begin
                exp_e = (c > rv_pulse_at);
                n_cmp++;
                if (proto_err !== exp_e) begin
                    n_bad++;
                    $display("FAIL %s err_in_addr c=%0d: got %b want %b", tag, c, proto_err, exp_e);
                end
            end
            if (c == ar_wait) m_arready = 1'b1;
            cyc();
            m_rvalid = 1'b0;
        end
        m_arready = 1'b0;
        #1;
        n_cmp++;
        if (m_arvalid !== 1'b0 || voice_gnt !== exp_g || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ar_accepted: got arvalid=%b gnt=%b busy=%b want arvalid=0 gnt=%b busy=1",
                     tag, m_arvalid, voice_gnt, busy, exp_g);
        end
    endtask

    // Drive last_at+1 beats with RLAST on the final one; done must pulse only there.
    task automatic data_phase(input int v, input int last_at, input string tag);
        logic [NV-1:0] exp_g;
        logic [NV-1:0] exp_d;
        exp_g = NV'(1) << v;
        for (int b = 0; b <= last_at; b++) begin
            m_rvalid = 1'b1;
            m_rready = 1'b1;
            m_rlast  = (b == last_at);
            #1;
            exp_d = (b == last_at) ? exp_g : '0;
            n_cmp++;
            if (voice_done !== exp_d) begin
                n_bad++;
                $display("FAIL %s done beat=%0d: got %b want %b", tag, b, voice_done, exp_d);
            end
            cyc();
        end
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
        voice_req[v] = 1'b0;
        #1;
        n_cmp++;
        if (voice_gnt !== '0 || busy !== 1'b0 || voice_done !== '0) begin
            n_bad++;
            $display("FAIL %s burst_end: got gnt=%b busy=%b done=%b want 0 0 0", tag, voice_gnt, busy, voice_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        voice_req = '0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast = 1'b0;
        for (int i = 0; i < NV; i++) begin
            addr_tab[i] = '0;
            len_tab[i]  = '0;
        end
        #2;
        rst_n = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (voice_gnt !== '0 || voice_done !== '0 || rd_voice_idx !== '0 || m_arvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b idx=%0d arvalid=%b want all 0",
                     voice_gnt, voice_done, rd_voice_idx, m_arvalid);
        end
        n_cmp++;
        if (m_araddr !== '0 || m_arlen !== '0 || busy !== 1'b0 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h len=%0d busy=%b err=%b want all 0",
                     m_araddr, m_arlen, busy, proto_err);
        end
    endtask

    task automatic test_all_four();
        for (int i = 0; i < NV; i++) begin
            addr_tab[i] = 32'h1000_0000 + 32'(i) * 32'h100;
        end
        len_tab[0] = 8'd0;
        len_tab[1] = 8'd1;
        len_tab[2] = 8'd2;
        len_tab[3] = 8'd0;
        voice_req = 4'b1111;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < NV; k++) begin
            addr_phase(k, 0, -1, 1, "rr_all");
            data_phase(k, int'(len_tab[k]), "rr_all");
        end
    endtask

    task automatic test_single();
        addr_tab[2] = 32'hBCD0_0040;
        len_tab[2]  = 8'd3;
        voice_req[2] = 1'b1;
        addr_phase(2, 2, -1, 1, "single");
        data_phase(2, 3, "single");
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single err: got %b want 0", proto_err);
        end
    endtask

    task automatic test_alternate();
        int order [4];
        order = '{1, 3, 1, 3};
        addr_tab[1] = 32'h3000_1000;
        addr_tab[3] = 32'h3000_3000;
        len_tab[1]  = 8'd1;
        len_tab[3]  = 8'd1;
        voice_req[1] = 1'b1;
        cyc();
        voice_req[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_phase(order[k], 0, -1, -1, "alternate");
            data_phase(order[k], 1, "alternate");
            if (k < 2) begin
                cyc();
                voice_req[order[k]] = 1'b1;
            end
        end
    endtask

    task automatic test_short_rlast();
        addr_tab[0] = 32'h2000_0000;
        len_tab[0]  = 8'd3;
        addr_tab[1] = 32'h2000_0800;
        len_tab[1]  = 8'd2;
        voice_req[0] = 1'b1;
        addr_phase(0, 0, -1, 1, "short_rlast");
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL short_rlast err_before: got %b want 0", proto_err);
        end
        data_phase(0, 1, "short_rlast");
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL short_rlast err_after: got %b want 1", proto_err);
        end
        voice_req[1] = 1'b1;
        addr_phase(1, 0, -1, 1, "after_err");
        data_phase(1, 2, "after_err");
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL after_err sticky: got %b want 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        addr_tab[0] = 32'h4000_0000;
        len_tab[0]  = 8'd1;
        addr_tab[1] = 32'h4000_0100;
        len_tab[1]  = 8'd0;
        voice_req[0] = 1'b1;
        addr_phase(0, 0, -1, 1, "reset_mid");
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        cyc();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (voice_gnt !== '0 || m_arvalid !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid drop: got gnt=%b arvalid=%b busy=%b err=%b want all 0",
                     voice_gnt, m_arvalid, busy, proto_err);
        end
        voice_req = 4'b0011;
        cyc();
        rst_n = 1'b1;
        addr_phase(0, 0, -1, 1, "reset_mid_v0");
        data_phase(0, 1, "reset_mid_v0");
        addr_phase(1, 0, -1, 1, "reset_mid_v1");
        data_phase(1, 0, "reset_mid_v1");
    endtask

    task automatic test_arready_stall();
        addr_tab[2] = 32'hCAFE_0000;
        len_tab[2]  = 8'd0;
        voice_req[2] = 1'b1;
        addr_phase(2, 100, 50, 1, "ar_stall");
        data_phase(2, 0, "ar_stall");
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_stall err_final: got %b want 1", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_alternate();
        test_short_rlast();
        test_reset_mid();
        test_arready_stall();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
